// File: rtl/discrete_pkg.sv
// Shared types and helpers for the discrete-audio RC/555 models.
package discrete_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHARGE,
    DISCHARGE
  } vco_state_e;

  localparam int GATE_FREE  = 0;
  localparam int GATE_GATED = 1;
  localparam int GATE_BURST = 2;

  // Per-sample RC coefficient in Q16: 2^51 / (fs * R * C*2^35), clamped to 1..65535.
  function automatic logic [15:0] rc_coef(input longint unsigned sample_rate,
                                          input longint unsigned r_ohm,
                                          input longint unsigned c_35);
    longint unsigned den;
    longint unsigned q;
    den = sample_rate * r_ohm * c_35;
    if (den == 0) return 16'hFFFF;
    q = (64'd1 << 51) / den;
    if (q < 64'd1) return 16'd1;
    if (q > 64'd65535) return 16'hFFFF;
    return q[15:0];
  endfunction

endpackage

// File: rtl/rc_exp_step.sv
// One sample of exponential RC approach toward a target, saturated to the signed range.
module rc_exp_step #(
  parameter int DATA_WIDTH   = 16,
  parameter bit TOWARD_LOWER = 1'b0
) (
  input  logic signed [DATA_WIDTH-1:0] cur,
  input  logic signed [DATA_WIDTH-1:0] target,
  input  logic        [15:0]           k,
  output logic signed [DATA_WIDTH-1:0] nxt
);

  localparam int W = 2 * DATA_WIDTH + 2;
  localparam logic signed [W-1:0] MAX_V = {{(W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V = {{(W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [W-1:0] cur_x;
  logic signed [W-1:0] tgt_x;
  logic signed [W-1:0] k_x;
  logic signed [W-1:0] diff;
  logic signed [W-1:0] prod;
  logic signed [W-1:0] step;
  logic signed [W-1:0] sum;

  // Discharge subtracts a floored step so the decay is cap - (cap*K)>>>16.
  always_comb begin
    cur_x = W'(cur);
    tgt_x = W'(target);
    k_x   = $signed({{(W-16){1'b0}}, k});
    diff  = TOWARD_LOWER ? (cur_x - tgt_x) : (tgt_x - cur_x);
    prod  = diff * k_x;
    step  = prod >>> 16;
    sum   = TOWARD_LOWER ? (cur_x - step) : (cur_x + step);
    if (sum > MAX_V)      nxt = MAX_V[DATA_WIDTH-1:0];
    else if (sum < MIN_V) nxt = MIN_V[DATA_WIDTH-1:0];
    else                  nxt = sum[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/gated_555_vco_voice.sv
// Astable 555 VCO at the audio sample rate with free-run, gated and burst modes.
module gated_555_vco_voice
  import discrete_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int SAMPLE_RATE  = 48000,
  parameter int R1           = 47000,
  parameter int R2           = 27000,
  parameter int C_35_SHIFTED = 1134,
  parameter int V_CC         = 6826,
  parameter int V_HIGH       = 6826,
  parameter int GATE_MODE    = 0,
  parameter int BURST_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         audio_clk_en,
  input  logic                         gate,
  input  logic signed [DATA_WIDTH-1:0] v_control,
  output logic signed [DATA_WIDTH-1:0] out,
  output logic signed [DATA_WIDTH-1:0] cap_v,
  output logic                         cycle_done,
  output logic                         active
);

  localparam logic [15:0] K_CH  = rc_coef(SAMPLE_RATE, R1 + R2, C_35_SHIFTED);
  localparam logic [15:0] K_DIS = rc_coef(SAMPLE_RATE, R2, C_35_SHIFTED);
  localparam logic signed [DATA_WIDTH-1:0] VCC_S   = DATA_WIDTH'(V_CC);
  localparam logic signed [DATA_WIDTH-1:0] VHIGH_S = DATA_WIDTH'(V_HIGH);
  localparam logic signed [DATA_WIDTH-1:0] THR_MIN = DATA_WIDTH'(64);
  localparam logic signed [DATA_WIDTH-1:0] ZERO_S  = '0;
  localparam logic [7:0] BURST8   = 8'(BURST_CYCLES);
  localparam bit         IS_GATED = (GATE_MODE == GATE_GATED);
  localparam bit         IS_BURST = (GATE_MODE == GATE_BURST);

  vco_state_e state_q, state_d;
  logic signed [DATA_WIDTH-1:0] cap_q, cap_d;
  logic [7:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic evt_q, evt_d;
  logic gate_prev_q;

  logic signed [DATA_WIDTH-1:0] upper, lower, ch_next, dis_next;
  logic pending;
  logic start;

  rc_exp_step #(.DATA_WIDTH(DATA_WIDTH), .TOWARD_LOWER(1'b0)) u_charge (
    .cur(cap_q), .target(VCC_S), .k(K_CH), .nxt(ch_next)
  );

  rc_exp_step #(.DATA_WIDTH(DATA_WIDTH), .TOWARD_LOWER(1'b1)) u_discharge (
    .cur(cap_q), .target(ZERO_S), .k(K_DIS), .nxt(dis_next)
  );

  always_comb begin
    upper = v_control;
    if (v_control < THR_MIN)    upper = THR_MIN;
    else if (v_control > VCC_S) upper = VCC_S;
    lower = upper >>> 1;
  end

  // A gate edge seen on a non-strobe clk is held until the next strobe consumes it.
  always_comb begin
    pending = evt_q | (gate & ~gate_prev_q);
    if (IS_BURST)      start = pending;
    else if (IS_GATED) start = gate;
    else               start = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    evt_d   = pending;
    if (audio_clk_en) begin
      evt_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          cap_d = dis_next;
          if (start) begin
            cap_d   = cap_q;
            state_d = (cap_q >= upper) ? DISCHARGE : CHARGE;
            if (IS_BURST) cnt_d = BURST8;
          end
        end
        CHARGE: begin
          cap_d = ch_next;
          if (ch_next >= upper) state_d = DISCHARGE;
        end
        DISCHARGE: begin
          cap_d = dis_next;
          if (dis_next <= lower) begin
            done_d  = 1'b1;
            state_d = CHARGE;
            if (IS_BURST) begin
              if (cnt_q <= 8'd1) begin
                cnt_d   = '0;
                state_d = IDLE;
              end else begin
                cnt_d = cnt_q - 8'd1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
      // Retrigger wins over a same-strobe burst end; gate-off wins over everything.
      if (IS_BURST && state_q != IDLE && pending) begin
        cnt_d = BURST8;
        if (state_d == IDLE) state_d = CHARGE;
      end
      if (IS_GATED && !gate) state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cap_q       <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      evt_q       <= 1'b0;
      gate_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      evt_q       <= evt_d;
      gate_prev_q <= gate;
    end
  end

  assign out        = (state_q == CHARGE) ? VHIGH_S : '0;
  assign active     = (state_q != IDLE);
  assign cap_v      = cap_q;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_gated_555_vco_voice.sv
// Bench for gated_555_vco_voice: sample-exact scoreboard on the free-run voice plus feature tests.
module tb_gated_555_vco_voice;

  localparam int VH = 6826;
  localparam longint KCH  = (longint'(1) << 51) / (longint'(48000) * 74000 * 1134);
  localparam longint KDIS = (longint'(1) << 51) / (longint'(48000) * 27000 * 1134);

  typedef struct {
    logic signed [15:0] out;
    logic signed [15:0] cap;
    logic               done;
    logic               act;
  } exp_t;

  logic clk, reset, audio_clk_en;
  logic g0, g1, g2, g3;
  logic signed [15:0] v0, v1, v2, v3;
  logic signed [15:0] o0, o1, o2, o3, c0, c1, c2, c3;
  logic d0, d1, d2, d3, a0, a1, a2, a3;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;
  int m_st, m_cap;
  logic m_done;

  gated_555_vco_voice #(.GATE_MODE(0)) u0 (
    .clk(clk), .reset(reset), .audio_clk_en(audio_clk_en), .gate(g0), .v_control(v0),
    .out(o0), .cap_v(c0), .cycle_done(d0), .active(a0));
  gated_555_vco_voice #(.GATE_MODE(1)) u1 (
    .clk(clk), .reset(reset), .audio_clk_en(audio_clk_en), .gate(g1), .v_control(v1),
    .out(o1), .cap_v(c1), .cycle_done(d1), .active(a1));
  gated_555_vco_voice #(.GATE_MODE(2), .BURST_CYCLES(4)) u2 (
    .clk(clk), .reset(reset), .audio_clk_en(audio_clk_en), .gate(g2), .v_control(v2),
    .out(o2), .cap_v(c2), .cycle_done(d2), .active(a2));
  gated_555_vco_voice #(.GATE_MODE(0), .V_CC(32767), .V_HIGH(32767)) u3 (
    .clk(clk), .reset(reset), .audio_clk_en(audio_clk_en), .gate(g3), .v_control(v3),
    .out(o3), .cap_v(c3), .cycle_done(d3), .active(a3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Reference 555 for u0 (free-run), written directly from the charge/discharge equations.
  task automatic model_step();
    int u, lo;
    u = int'(v0);
    if (u < 64) u = 64;
    if (u > VH) u = VH;
    lo = u / 2;
    m_done = 1'b0;
    case (m_st)
      0: m_st = (m_cap >= u) ? 2 : 1;
      1: begin
        m_cap = sat16(m_cap + ((longint'(VH - m_cap) * KCH) >>> 16));
        if (m_cap >= u) m_st = 2;
      end
      default: begin
        m_cap = sat16(m_cap - ((longint'(m_cap) * KDIS) >>> 16));
        if (m_cap <= lo) begin
          m_done = 1'b1;
          m_st   = 1;
        end
      end
    endcase
  endtask

  task automatic tick(input logic en);
    exp_t e;
    audio_clk_en = en;
    if (reset) begin
      m_st = 0; m_cap = 0; m_done = 1'b0;
    end else if (en) begin
      model_step();
    end else begin
      m_done = 1'b0;
    end
    e.out  = (m_st == 1) ? 16'(VH) : 16'sd0;
    e.cap  = 16'(m_cap);
    e.done = m_done;
    e.act  = (m_st != 0);
    @(posedge clk);
    sb_q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checks++;
      if (o0 !== e.out || c0 !== e.cap || d0 !== e.done || a0 !== e.act) begin
        failures++;
        $display("FAIL scoreboard t=%0t out=%0d want %0d cap=%0d want %0d done=%b want %b active=%b want %b",
                 $time, o0, e.out, c0, e.cap, d0, e.done, a0, e.act);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick(0);
    checks++;
    if (o0 !== 16'sd0 || c0 !== 16'sd0 || a0 !== 1'b0 || d0 !== 1'b0 ||
        c1 !== 16'sd0 || a1 !== 1'b0 || c2 !== 16'sd0 || a2 !== 1'b0 || c3 !== 16'sd0 || a3 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state out0=%0d cap0=%0d act=%b%b%b%b want out=0 cap=0 active=0", o0, c0, a0, a1, a2, a3);
    end
    reset = 1'b0;
    tick(0);
  endtask

  task automatic test_free_run();
    int nd = 0, last = 0, hi = 0, per;
    int cmin = 32767, cmax = -32768;
    for (int s = 1; s <= 1500 && nd < 9; s++) begin
      tick(1);
      if (nd >= 5) begin
        if (c0 < cmin) cmin = c0;
        if (c0 > cmax) cmax = c0;
      end
      if (d0) begin
        nd++;
        if (nd >= 6) begin
          per = s - last;
          checks++;
          if (per < 100 || per > 122) begin
            failures++;
            $display("FAIL free_period got %0d strobes want 100..122", per);
          end
          checks++;
          if (hi * 100 < 60 * per || hi * 100 > 75 * per) begin
            failures++;
            $display("FAIL free_duty high %0d of %0d strobes want 60..75%%", hi, per);
          end
        end
        last = s;
        hi = 0;
      end
      if (o0 == 16'(VH)) hi++;
      tick(0);
    end
    checks++;
    if (nd < 9) begin
      failures++;
      $display("FAIL free_timeout cycle_done count %0d want 9", nd);
    end
    // Bounds allow one sample step of overshoot past each threshold.
    checks++;
    if (cmax < 4500 || cmax > 4642 || cmin < 2200 || cmin > 2320) begin
      failures++;
      $display("FAIL free_swing cap range %0d..%0d want ~2275..~4551", cmin, cmax);
    end
  endtask

  task automatic test_vctl_step();
    int nd = 0, last = 0, per, cmax = -32768;
    v0 = 16'sd3000;
    for (int s = 1; s <= 600 && nd < 3; s++) begin
      tick(1);
      if (nd == 2 && c0 > cmax) cmax = c0;
      if (d0) begin
        nd++;
        if (nd == 2) last = s;
        if (nd == 3) begin
          per = s - last;
          checks++;
          if (per >= 90) begin
            failures++;
            $display("FAIL step_period got %0d strobes want <90", per);
          end
          checks++;
          if (c0 > 16'sd1500 || c0 < 16'sd1460) begin
            failures++;
            $display("FAIL step_lower cap at cycle end %0d want 1460..1500", c0);
          end
        end
      end
      tick(0);
    end
    checks++;
    if (nd < 3 || cmax < 3000 || cmax > 3040) begin
      failures++;
      $display("FAIL step_upper dones %0d peak cap %0d want 3 and 3000..3040", nd, cmax);
    end
    v0 = 16'sd4551;
  endtask

  task automatic test_gated();
    int nd = 0;
    bit found = 0, mono = 1, any_done = 0, any_act = 0;
    logic signed [15:0] prev, first;
    for (int s = 0; s < 20; s++) begin
      tick(1);
      if (o1 !== 16'sd0 || a1 !== 1'b0) any_act = 1;
      tick(0);
    end
    checks++;
    if (any_act) begin
      failures++;
      $display("FAIL gate_low_idle out=%0d active=%b want 0 0", o1, a1);
    end
    g1 = 1'b1;
    for (int s = 0; s < 500; s++) begin
      tick(1);
      if (d1) nd++;
      tick(0);
    end
    checks++;
    if (nd < 3) begin
      failures++;
      $display("FAIL gate_run cycle_done count %0d want >=3", nd);
    end
    for (int s = 0; s < 300 && !found; s++) begin
      tick(1);
      if (o1 == 16'(VH)) found = 1;
      tick(0);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL gate_wait_charge timeout out=%0d want %0d", o1, VH);
    end
    prev = c1;
    g1 = 1'b0;
    tick(1);
    checks++;
    if (o1 !== 16'sd0 || a1 !== 1'b0 || d1 !== 1'b0) begin
      failures++;
      $display("FAIL gate_off out=%0d active=%b done=%b want 0 0 0", o1, a1, d1);
    end
    tick(0);
    first = c1;
    prev = c1;
    for (int s = 0; s < 50; s++) begin
      tick(1);
      if (c1 > prev) mono = 0;
      if (d1 || a1) any_done = 1;
      prev = c1;
      tick(0);
    end
    checks++;
    if (!mono || any_done || !(prev < first)) begin
      failures++;
      $display("FAIL gate_decay monotonic=%b done_or_active=%b cap %0d->%0d want 1 0 falling", mono, any_done, first, prev);
    end
    g1 = 1'b1;
    tick(0);
    tick(1);
    checks++;
    if (o1 !== 16'(VH) || c1 < prev || c1 == 16'sd0) begin
      failures++;
      $display("FAIL gate_resume out=%0d cap=%0d want %0d and cap>=%0d", o1, c1, VH, prev);
    end
    tick(0);
    g1 = 1'b0;
  endtask

  task automatic burst_run(input bit retrigger, output int nd, output bit idle_ok);
    bit started = 0;
    bit pulsed2 = 0;
    nd = 0;
    idle_ok = 0;
    g2 = 1'b1;
    tick(0);
    g2 = 1'b0;
    for (int s = 0; s < 1500; s++) begin
      tick(1);
      if (a2) started = 1;
      if (d2) nd++;
      if (started && !a2) begin
        idle_ok = 1;
        tick(0);
        break;
      end
      if (retrigger && nd == 2 && !pulsed2) begin
        pulsed2 = 1;
        g2 = 1'b1;
        tick(0);
        g2 = 1'b0;
      end else begin
        tick(0);
      end
    end
  endtask

  task automatic test_burst();
    int nd;
    bit idle_ok;
    bit extra = 0;
    burst_run(1'b0, nd, idle_ok);
    checks++;
    if (nd != 4 || !idle_ok) begin
      failures++;
      $display("FAIL burst_single cycle_done count %0d idle=%b want 4 1", nd, idle_ok);
    end
    for (int s = 0; s < 30; s++) begin
      tick(1);
      if (d2 || a2) extra = 1;
      tick(0);
    end
    checks++;
    if (extra) begin
      failures++;
      $display("FAIL burst_after active_or_done=%b want 0", extra);
    end
    burst_run(1'b1, nd, idle_ok);
    checks++;
    if (nd != 6 || !idle_ok) begin
      failures++;
      $display("FAIL burst_retrigger cycle_done count %0d idle=%b want 6 1", nd, idle_ok);
    end
  endtask

  task automatic test_reset_mid_discharge();
    bit found = 0;
    for (int s = 0; s < 300 && !found; s++) begin
      tick(1);
      if (a0 && o0 == 16'sd0) found = 1;
      else tick(0);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rst_wait_discharge timeout active=%b out=%0d", a0, o0);
    end
    reset = 1'b1;
    tick(0);
    reset = 1'b0;
    checks++;
    if (o0 !== 16'sd0 || c0 !== 16'sd0 || a0 !== 1'b0 || c3 !== 16'sd0) begin
      failures++;
      $display("FAIL rst_mid out=%0d cap=%0d active=%b cap3=%0d want 0 0 0 0", o0, c0, a0, c3);
    end
    tick(0);
    tick(1);
    checks++;
    if (a0 !== 1'b1 || o0 !== 16'(VH)) begin
      failures++;
      $display("FAIL rst_resume active=%b out=%0d want 1 %0d", a0, o0, VH);
    end
    tick(0);
  endtask

  task automatic test_saturation();
    bit neg = 0, saw_hi = 0, saw_lo = 0;
    int nd = 0;
    for (int s = 0; s < 300; s++) begin
      tick(1);
      if (c3 < 16'sd0) neg = 1;
      tick(0);
    end
    checks++;
    if (neg) begin
      failures++;
      $display("FAIL sat_full_scale cap went negative, last cap=%0d", c3);
    end
    v3 = 16'sd30000;
    for (int s = 0; s < 1200 && nd < 2; s++) begin
      tick(1);
      if (c3 < 16'sd0) neg = 1;
      if (o3 == 16'sd32767) saw_hi = 1;
      if (o3 == 16'sd0 && a3) saw_lo = 1;
      if (d3) nd++;
      tick(0);
    end
    checks++;
    if (neg || nd < 2 || !saw_hi || !saw_lo) begin
      failures++;
      $display("FAIL sat_toggle neg=%b dones=%0d hi=%b lo=%b want 0 >=2 1 1", neg, nd, saw_hi, saw_lo);
    end
  endtask

  initial begin
    reset = 1'b1;
    audio_clk_en = 1'b0;
    g0 = 1'b0; g1 = 1'b0; g2 = 1'b0; g3 = 1'b0;
    v0 = 16'sd4551; v1 = 16'sd4551; v2 = 16'sd4551; v3 = 16'sd32767;
    m_st = 0; m_cap = 0; m_done = 1'b0;
    test_reset();
    test_free_run();
    test_vctl_step();
    test_gated();
    test_burst();
    test_reset_mid_discharge();
    test_saturation();
    tick(0);
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending %0d want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
